step_select_db: RTL

Parametrised, registered successor to the combinational switch-to-step-count priority encoder. Synchronises and debounces an N-bit switch bank, priority-encodes it to a step count (highest active switch index + 1, 0 when none), and presents a stable, registered `steps` value to the step generator core. The block has two modes. In live mode, any debounced change is applied. In commit mode, a debounced candidate is held until `load` is pulsed.

---
 rtl/step_gen_pkg.sv | 15 +
 rtl/sw_prio_enc.sv | 18 +
 rtl/step_select_db.sv | 70 +++++++
 3 files changed

// File: rtl/step_gen_pkg.sv
// step_gen_pkg: shared types, defaults and width helpers for the step generator blocks
package step_gen_pkg;

    typedef enum logic {
        ST_SETTLING,
        ST_STABLE
    } db_state_e;

    localparam int DB_CYCLES_1MS = 100000;

    function automatic int step_w(input int n_sw);
        return $clog2(n_sw + 1);
    endfunction

endpackage

// File: rtl/sw_prio_enc.sv
// sw_prio_enc: combinational highest-set-bit encoder, index + 1 or 0 when no bit is set
module sw_prio_enc
    import step_gen_pkg::*;
#(
    parameter int N_SW   = 10,
    parameter int STEP_W = step_w(N_SW)
) (
    input  logic [N_SW-1:0]   sw,
    output logic [STEP_W-1:0] enc
);

    always_comb begin
        enc = '0;
        for (int i = 0; i < N_SW; i++)
            if (sw[i]) enc = STEP_W'(i + 1);
    end

endmodule

// File: rtl/step_select_db.sv
// step_select_db: synchronised, debounced switch-to-step-count selector with live and commit modes
module step_select_db
    import step_gen_pkg::*;
#(
    parameter int N_SW      = 10,
    parameter int STEP_W    = step_w(N_SW),
    parameter int DB_CYCLES = DB_CYCLES_1MS,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SW-1:0]   sw,
    input  logic              mode,
    input  logic              load,
    output logic [STEP_W-1:0] steps,
    output logic              steps_changed,
    output logic              pending
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [N_SW-1:0]   sw_s1, sw_s2;
    logic [STEP_W-1:0] enc, cand, cand_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    db_state_e         state, state_nxt;
    logic              apply;

    sw_prio_enc #(.N_SW(N_SW), .STEP_W(STEP_W)) u_enc (
        .sw  (sw_s2),
        .enc (enc)
    );

    assign apply   = state == ST_STABLE && cand != steps && (!mode || load);
    assign pending = mode && state == ST_STABLE && cand != steps;

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        if (enc != cand) begin
            cand_nxt  = enc;
            cnt_nxt   = '0;
            state_nxt = ST_SETTLING;
        end else if (state == ST_SETTLING) begin
            cnt_nxt   = cnt + 1'b1;
            state_nxt = (cnt_nxt == CNT_LAST) ? ST_STABLE : ST_SETTLING;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_s1         <= '0;
            sw_s2         <= '0;
            cand          <= '0;
            cnt           <= '0;
            state         <= ST_SETTLING;
            steps         <= '0;
            steps_changed <= 1'b0;
        end else begin
            sw_s1         <= sw;
            sw_s2         <= sw_s1;
            cand          <= cand_nxt;
            cnt           <= cnt_nxt;
            state         <= state_nxt;
            steps         <= apply ? cand : steps;
            steps_changed <= apply;
        end
    end

endmodule
